// File: rtl/prewish5k_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prewish5k_pkg
// Description : Shared types and constants for the prewish5k mask scheduler.
//               Holds the scheduler state encoding, the mask width and the
//               default ring depth and dwell widths.
// Revision    : 1.0 - initial release
// ============================================================================
package prewish5k_pkg;

  localparam int MASK_W             = 8;
  localparam int DEFAULT_DEPTH_BITS = 2;
  localparam int DEFAULT_DWELL_BITS = 26;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_DWELL   = 2'd2
  } sched_state_t;

endpackage : prewish5k_pkg
`default_nettype wire

// File: rtl/prewish5k_mask_ring.sv
`default_nettype none
// ============================================================================
// Module      : prewish5k_mask_ring
// Description : Ring storage of user-loaded blink masks with write pointer and
//               occupancy count. Loads into a full ring are dropped and
//               reported with a one-cycle overflow pulse. Clear has priority
//               over a simultaneous load.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               i_load          - write i_wdata at the write pointer
//               i_clear         - empty the ring (count and pointer to zero)
//               i_wdata         - mask to store
//               i_rd_idx        - combinational read address
//               o_rd_data       - ring[i_rd_idx]
//               o_count         - number of stored masks (registered)
//               o_overflow      - registered pulse for a dropped load
// Revision    : 1.0 - initial release
// ============================================================================
module prewish5k_mask_ring
  import prewish5k_pkg::*;
#(
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [MASK_W-1:0]     i_wdata,
  input  logic [DEPTH_BITS-1:0] i_rd_idx,
  output logic [MASK_W-1:0]     o_rd_data,
  output logic [DEPTH_BITS:0]   o_count,
  output logic                  o_overflow
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [MASK_W-1:0]     ring_q [DEPTH];
  logic [MASK_W-1:0]     ring_d [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  w_full;

  assign w_full = (count_q == FULL_COUNT);

  always_comb begin
    ring_d     = ring_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    if (i_clear) begin
      // Clear wins over a same-edge load; the load is silently discarded.
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (i_load) begin
      if (w_full) begin
        overflow_d = 1'b1;
      end else begin
        ring_d[wr_ptr_q] = i_wdata;
        wr_ptr_d         = wr_ptr_q + 1'b1;
        count_d          = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    ring_q <= ring_d;
  end

  assign o_rd_data  = ring_q[i_rd_idx];
  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule : prewish5k_mask_ring
`default_nettype wire

// File: rtl/prewish5k_mask_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : prewish5k_mask_scheduler
// Description : Rotates through the stored blink masks and presents each one
//               to the blinky over a STB_O/ACK_I handshake, holding it for
//               2^DWELL_BITS cycles after acknowledge before moving on.
// Ports       : CLK_I, RST_I    - clock, asynchronous active-high reset
//               i_load, i_clear - button load pulse, ring clear pulse
//               i_mask_n        - active-low DIP mask (stored inverted)
//               STB_O, DAT_O    - mask strobe and data to the blinky
//               ACK_I           - blinky acceptance of DAT_O
//               o_count         - number of stored masks
//               o_cur_idx       - ring index of the current/last mask
//               o_overflow      - pulse when a load hits a full ring
// Revision    : 1.0 - initial release
// ============================================================================
module prewish5k_mask_scheduler
  import prewish5k_pkg::*;
#(
  parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS,
  parameter int DWELL_BITS = DEFAULT_DWELL_BITS
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [MASK_W-1:0]     i_mask_n,
  output logic                  STB_O,
  output logic [MASK_W-1:0]     DAT_O,
  input  logic                  ACK_I,
  output logic [DEPTH_BITS:0]   o_count,
  output logic [DEPTH_BITS-1:0] o_cur_idx,
  output logic                  o_overflow
);

  sched_state_t          state_q, state_d;
  logic [DEPTH_BITS-1:0] idx_q, idx_d;
  logic [DWELL_BITS-1:0] dwell_q, dwell_d;
  logic                  stb_q, stb_d;
  logic [MASK_W-1:0]     dat_q, dat_d;
  logic                  armed_q, armed_d;

  logic                  w_load;
  logic                  w_clear;
  logic                  w_ack;
  logic [MASK_W-1:0]     w_rd_data;
  logic [DEPTH_BITS:0]   w_count;
  logic [DEPTH_BITS:0]   w_idx_inc;
  logic [DEPTH_BITS-1:0] w_idx_adv;

  // The first edge after reset release only arms the block; every input is
  // ignored on that edge.
  assign armed_d = 1'b1;
  assign w_load  = i_load  & armed_q;
  assign w_clear = i_clear & armed_q;
  assign w_ack   = ACK_I   & armed_q;

  prewish5k_mask_ring #(
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ring (
    .clk        (CLK_I),
    .rst        (RST_I),
    .i_load     (w_load),
    .i_clear    (w_clear),
    .i_wdata    (~i_mask_n),
    .i_rd_idx   (idx_d),
    .o_rd_data  (w_rd_data),
    .o_count    (w_count),
    .o_overflow (o_overflow)
  );

  // Wrap against the live count (one bit wider than idx) so masks appended
  // mid-rotation join at the next advance and idx never lands on an
  // unwritten entry.
  assign w_idx_inc = {1'b0, idx_q} + 1'b1;
  assign w_idx_adv = (w_idx_inc >= w_count) ? '0 : w_idx_inc[DEPTH_BITS-1:0];

  // State register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      stb_q   <= 1'b0;
      dat_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      stb_q   <= stb_d;
      dat_q   <= dat_d;
      armed_q <= armed_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    if (w_clear) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      dwell_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Registered count is non-zero one edge after the first load.
          if (w_count != '0) begin
            state_d = ST_PRESENT;
            idx_d   = '0;
          end
        end
        ST_PRESENT: begin
          if (w_ack) begin
            state_d = ST_DWELL;
            dwell_d = '0;
          end
        end
        ST_DWELL: begin
          dwell_d = dwell_q + 1'b1;
          if (dwell_q == '1) begin
            state_d = ST_PRESENT;
            idx_d   = w_idx_adv;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          dwell_d = '0;
        end
      endcase
    end
  end

  // Output logic: outputs are registered from the next state, and DAT_O is
  // captured only on entry to PRESENT so it stays stable until acknowledged.
  always_comb begin
    stb_d = (state_d == ST_PRESENT);
    dat_d = dat_q;
    if ((state_d == ST_PRESENT) && (state_q != ST_PRESENT)) begin
      dat_d = w_rd_data;
    end
  end

  assign STB_O     = stb_q;
  assign DAT_O     = dat_q;
  assign o_count   = w_count;
  assign o_cur_idx = idx_q;

endmodule : prewish5k_mask_scheduler
`default_nettype wire
